// File: rtl/temp_ctrl_pkg.sv
// temp_ctrl_pkg: shared state encoding, sample width, default thresholds and the hysteresis rule
// Contents: TEMP_W, default fan/alarm thresholds, state_t, and hyst_next().
// hyst_next() returns the next on/off value for one hysteresis channel.
package temp_ctrl_pkg;
  localparam int TEMP_W = 5;
  localparam int FAN_ON_DEF = 25;
  localparam int FAN_OFF_DEF = 23;
  localparam int ALARM_ON_DEF = 30;
  localparam int ALARM_OFF_DEF = 28;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_EVAL} state_t;
  function automatic logic hyst_next(input logic [TEMP_W-1:0] v, input int on, input int off,
                                     input logic frc, input logic cur);
    return (int'(v) >= on || frc) ? 1'b1 : (int'(v) <= off) ? 1'b0 : cur;
  endfunction
endpackage

// File: rtl/hyst_cmp.sv
// hyst_cmp: registered on/off state with ON/OFF hysteresis thresholds
// Ports: clk, reset (sync, active-low), value (sample), update (evaluate this cycle),
//        force_on (hold the output on regardless of value), state (registered result).
module hyst_cmp
  import temp_ctrl_pkg::*;
#(
  parameter int ON = FAN_ON_DEF,
  parameter int OFF = FAN_OFF_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TEMP_W-1:0] value,
  input  logic              update,
  input  logic              force_on,
  output logic              state
);
  always_ff @(posedge clk) begin
    if (!reset) state <= 1'b0;
    else if (update) state <= hyst_next(value, ON, OFF, force_on, state);
  end
endmodule

// File: rtl/temp_sample_ctrl.sv
// temp_sample_ctrl: periodic sensor sampling over req/ack with timeout, plus fan/alarm hysteresis
// Ports: clk, reset (sync, active-low), en_m1 (periodic enable), lect (manual read),
//        rd_req/rd_ack/temperatura (sensor handshake), temp_out/temp_valid (captured sample),
//        est_ventilador (fan), est_alarma (alarm), sensor_err (last request timed out).
module temp_sample_ctrl
  import temp_ctrl_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int TIMEOUT = 16,
  parameter int FAN_ON = FAN_ON_DEF,
  parameter int FAN_OFF = FAN_OFF_DEF,
  parameter int ALARM_ON = ALARM_ON_DEF,
  parameter int ALARM_OFF = ALARM_OFF_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_m1,
  input  logic              lect,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [TEMP_W-1:0] temperatura,
  output logic [TEMP_W-1:0] temp_out,
  output logic              temp_valid,
  output logic              est_ventilador,
  output logic              est_alarma,
  output logic              sensor_err
);
  localparam int PW = $clog2(PRESCALE);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic tick, tmo, got, upd, alarm_nxt;
  assign tick = pcnt == PW'(PRESCALE - 1);
  assign tmo = tcnt == TW'(TIMEOUT - 1);
  assign got = state == S_REQ && rd_ack;
  assign upd = state == S_EVAL;
  // An ack always wins, even on the cycle the timeout would expire.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = en_m1 ? S_WAIT : S_IDLE;
      S_WAIT: state_n = !en_m1 ? S_IDLE : (tick || lect) ? S_REQ : S_WAIT;
      S_REQ:  state_n = rd_ack ? S_EVAL : !en_m1 ? S_IDLE : tmo ? S_WAIT : S_REQ;
      S_EVAL: state_n = en_m1 ? S_WAIT : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      pcnt <= '0;
      tcnt <= '0;
      rd_req <= 1'b0;
      temp_out <= '0;
      temp_valid <= 1'b0;
      sensor_err <= 1'b0;
    end else begin
      state <= state_n;
      pcnt <= (state == S_WAIT && state_n == S_WAIT) ? pcnt + 1'b1 : '0;
      tcnt <= (state == S_REQ && state_n == S_REQ) ? tcnt + 1'b1 : '0;
      rd_req <= state_n == S_REQ;
      temp_valid <= got;
      if (got) temp_out <= temperatura;
      sensor_err <= got ? 1'b0 : (state == S_REQ && state_n == S_WAIT) ? 1'b1 : sensor_err;
    end
  end
  // The fan must see the alarm value being written this cycle, not the stale one.
  assign alarm_nxt = hyst_next(temp_out, ALARM_ON, ALARM_OFF, 1'b0, est_alarma);
  hyst_cmp #(.ON(ALARM_ON), .OFF(ALARM_OFF)) u_alarm (
    .clk(clk), .reset(reset), .value(temp_out), .update(upd), .force_on(1'b0), .state(est_alarma)
  );
  hyst_cmp #(.ON(FAN_ON), .OFF(FAN_OFF)) u_fan (
    .clk(clk), .reset(reset), .value(temp_out), .update(upd), .force_on(alarm_nxt),
    .state(est_ventilador)
  );
endmodule

// File: tb/tb_temp_sample_ctrl.sv
// tb_temp_sample_ctrl: directed stimulus with an observation-level model of temp_sample_ctrl
module tb_temp_sample_ctrl;
  localparam int PRESCALE = 8;
  localparam int TIMEOUT = 4;
  logic clk = 1'b0, reset = 1'b0, en_m1 = 1'b0, lect = 1'b0, rd_ack = 1'b0, ack_en = 1'b1;
  logic [4:0] temperatura = 5'd0, temp_out;
  logic rd_req, temp_valid, est_ventilador, est_alarma, sensor_err;
  int n_chk = 0, n_fail = 0;
  temp_sample_ctrl #(.PRESCALE(PRESCALE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .en_m1(en_m1), .lect(lect), .rd_req(rd_req), .rd_ack(rd_ack),
    .temperatura(temperatura), .temp_out(temp_out), .temp_valid(temp_valid),
    .est_ventilador(est_ventilador), .est_alarma(est_alarma), .sensor_err(sensor_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Sensor answers one cycle after it sees a request, when enabled.
  always @(posedge clk) begin
    #2;
    rd_ack = ack_en && rd_req;
  end
  // Model: observes the handshake and derives every output from the behavioural rules.
  logic p_rst = 1'b0, p_hs = 1'b0, p_tmo = 1'b0, p_abort = 1'b0, p_upd = 1'b0;
  logic [4:0] p_val = 5'd0, m_temp = 5'd0;
  logic m_fan = 1'b0, m_alarm = 1'b0, m_err = 1'b0;
  int run = 0;
  always @(negedge clk) begin
    if (!p_rst) begin
      m_temp = 0; m_fan = 0; m_alarm = 0; m_err = 0; p_upd = 0;
      chk("rst_rd_req", rd_req, 0);
      chk("rst_temp_out", temp_out, 0);
      chk("rst_temp_valid", temp_valid, 0);
      chk("rst_fan", est_ventilador, 0);
      chk("rst_alarm", est_alarma, 0);
      chk("rst_err", sensor_err, 0);
    end else begin
      if (p_upd) begin
        if (m_temp >= 30) m_alarm = 1;
        else if (m_temp <= 28) m_alarm = 0;
        if (m_temp >= 25 || m_alarm) m_fan = 1;
        else if (m_temp <= 23) m_fan = 0;
      end
      if (p_hs) begin m_temp = p_val; m_err = 0; end
      if (p_tmo) m_err = 1;
      chk("m_temp_out", temp_out, m_temp);
      chk("m_temp_valid", temp_valid, p_hs);
      chk("m_fan", est_ventilador, m_fan);
      chk("m_alarm", est_alarma, m_alarm);
      chk("m_err", sensor_err, m_err);
      if (p_hs || p_tmo || p_abort) chk("m_req_drop", rd_req, 0);
      p_upd = p_hs;
    end
    p_rst = reset;
    p_hs = rd_req && rd_ack;
    p_val = temperatura;
    run = rd_req ? run + 1 : 0;
    p_tmo = rd_req && !rd_ack && en_m1 && run == TIMEOUT;
    p_abort = rd_req && !rd_ack && !en_m1;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_req(output int k);
    k = 0;
    while (!rd_req && k < 60) begin step(); k++; end
    if (!rd_req) chk("req_wait_expired", 0, 1);
  endtask
  task automatic sample(input logic [4:0] v, input logic f, input logic a);
    int k = 0;
    temperatura = v;
    while (!temp_valid && k < 60) begin step(); k++; end
    if (!temp_valid) chk("valid_wait_expired", 0, 1);
    chk("temp_out", temp_out, v);
    step();
    chk("valid_pulse_end", temp_valid, 0);
    chk("fan", est_ventilador, f);
    chk("alarm", est_alarma, a);
  endtask
  initial begin
    int k;
    repeat (3) step();
    chk("rst_rd_req_lit", rd_req, 0);
    reset = 1; en_m1 = 1; temperatura = 10;
    step();
    wait_req(k);
    chk("first_req_delay", k, 8);
    sample(10, 0, 0);
    sample(20, 0, 0);
    sample(25, 1, 0);
    sample(24, 1, 0);
    sample(23, 0, 0);
    sample(30, 1, 1);
    sample(29, 1, 1);
    sample(28, 1, 0);
    sample(24, 1, 0);
    ack_en = 0;
    wait_req(k);
    k = 0;
    while (rd_req && k < 20) begin step(); k++; end
    chk("timeout_req_len", k, 4);
    chk("timeout_err", sensor_err, 1);
    chk("timeout_temp_hold", temp_out, 24);
    ack_en = 1;
    sample(12, 0, 0);
    chk("err_cleared", sensor_err, 0);
    repeat (3) step();
    lect = 1;
    step();
    chk("lect_req", rd_req, 1);
    sample(31, 1, 1);
    lect = 0; ack_en = 0;
    wait_req(k);
    chk("periodic_after_eval", k, 8);
    en_m1 = 0;
    step();
    chk("abort_req", rd_req, 0);
    chk("abort_valid", temp_valid, 0);
    chk("abort_err", sensor_err, 0);
    chk("abort_temp", temp_out, 31);
    repeat (10) step();
    chk("idle_no_req", rd_req, 0);
    en_m1 = 1;
    step();
    wait_req(k);
    chk("idle_restart_req", k, 8);
    k = 0;
    while (rd_req && k < 20) begin step(); k++; end
    chk("timeout2_len", k, 4);
    chk("timeout2_err", sensor_err, 1);
    wait_req(k);
    reset = 0;
    step();
    chk("midreq_rst_req", rd_req, 0);
    chk("midreq_rst_temp", temp_out, 0);
    chk("midreq_rst_fan", est_ventilador, 0);
    chk("midreq_rst_alarm", est_alarma, 0);
    chk("midreq_rst_err", sensor_err, 0);
    reset = 1; en_m1 = 0;
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
